mem_stream_loader: RTL and testbench

- Upstream feeder for the 32 x 32-bit single-port on-chip RAM (Avalon slave s1).
- Accepts a byte stream, for example from a UART receiver or JTAG bridge.
- Packs each group of four bytes into one little-endian word and writes words 0..DEPTH-1 with debugaccess asserted, because the RAM only writes when debugaccess is high.
- After the last write, reads the whole RAM back and checks a running checksum. It then reports done, plus error on mismatch.

---
 rtl/mem_loader_pkg.sv | 18 +
 rtl/mem_stream_loader_byte_packer.sv | 49 ++++
 rtl/mem_stream_loader.sv | 164 ++++++++++++++++
 tb/tb_mem_stream_loader.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the RAM stream loader.
package mem_loader_pkg;

  localparam int         BYTES_PER_WORD = 4;
  localparam logic [3:0] BE_ALL         = 4'hF;
  localparam int         DEPTH_DEFAULT  = 32;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    RD_ADDR,
    RD_DATA,
    CHECK,
    DONE
  } state_e;

endpackage

// File: rtl/mem_stream_loader_byte_packer.sv
// Packs accepted stream bytes into little-endian words; the first byte lands in bits [7:0].
module byte_packer
  import mem_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear_i,
  input  logic [7:0]                  byte_i,
  input  logic                        valid_i,
  input  logic                        ready_i,
  output logic [BYTES_PER_WORD*8-1:0] word_o,
  output logic                        word_valid_o
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]                  lane_q, lane_d;
  logic [BYTES_PER_WORD*8-1:0] word_q, word_d;
  logic                        accept;

  assign accept = valid_i & ready_i;

  always_comb begin
    // NOTE: defaults first, so every path assigns every next-state and no latch is inferred.
    lane_d = lane_q;
    word_d = word_q;
    if (clear_i) begin
      lane_d = '0;
    end else if (accept) begin
      word_d[{lane_q, 3'b000} +: 8] = byte_i;
      lane_d                        = lane_q + 2'd1;
    end
  end

  assign word_valid_o = accept & ~clear_i & (lane_q == LAST_LANE);
  assign word_o       = word_q;

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      lane_q <= '0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/mem_stream_loader.sv
// Loads a byte stream into the on-chip RAM word by word, then reads it back and verifies a checksum.
module mem_stream_loader
  import mem_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_debugaccess,
  output logic              mem_clken,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wsum_q, wsum_d;
  logic [DATA_W-1:0]   vsum_q, vsum_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;
  logic                error_q, error_d;
  logic [DATA_W-1:0]   word;
  logic                word_valid;
  logic                kill;

  assign kill = abort & (state_q != IDLE);

  // Lane counter is held clear outside a load so every load starts on byte lane 0.
  byte_packer u_packer (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_i      ((state_q == IDLE) | kill),
    .byte_i       (in_data),
    .valid_i      (in_valid),
    .ready_i      (in_ready),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wsum_d          = wsum_q;
    vsum_d          = vsum_q;
    checksum_d      = checksum_q;
    error_d         = error_q;
    in_ready        = 1'b0;
    mem_chipselect  = 1'b0;
    mem_write       = 1'b0;
    mem_debugaccess = 1'b0;
    mem_writedata   = '0;
    done            = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COLLECT;
          addr_d  = '0;
          wsum_d  = '0;
          vsum_d  = '0;
          error_d = 1'b0;
        end
      end
      COLLECT: begin
        in_ready = 1'b1;
        if (word_valid) state_d = WRITE;
      end
      WRITE: begin
        // The RAM ignores writes unless debugaccess accompanies them.
        mem_chipselect  = 1'b1;
        mem_write       = ~kill;
        mem_debugaccess = 1'b1;
        mem_writedata   = word;
        wsum_d          = wsum_q + word;
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = RD_ADDR;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = COLLECT;
        end
      end
      RD_ADDR: begin
        mem_chipselect = 1'b1;
        state_d        = RD_DATA;
      end
      RD_DATA: begin
        mem_chipselect = 1'b1;
        vsum_d         = vsum_q + mem_readdata;
        if (addr_q == LAST_ADDR) begin
          state_d = CHECK;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = RD_ADDR;
        end
      end
      CHECK: begin
        error_d    = (vsum_q != wsum_q);
        checksum_d = wsum_q;
        state_d    = DONE;
      end
      DONE: begin
        done    = ~kill;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything: leave all bookkeeping untouched and fall back to IDLE.
    if (kill) begin
      state_d    = IDLE;
      addr_d     = addr_q;
      wsum_d     = wsum_q;
      vsum_d     = vsum_q;
      checksum_d = checksum_q;
      error_d    = error_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      wsum_q     <= '0;
      vsum_q     <= '0;
      checksum_q <= '0;
      error_q    <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      wsum_q     <= wsum_d;
      vsum_q     <= vsum_d;
      checksum_q <= checksum_d;
      error_q    <= error_d;
    end
  end

  assign mem_address    = addr_q;
  assign mem_byteenable = BE_ALL;
  assign mem_clken      = 1'b1;
  assign busy           = (state_q != IDLE);
  assign error          = error_q;
  assign checksum       = checksum_q;

endmodule

// File: tb/tb_mem_stream_loader.sv
// Bench for mem_stream_loader: RAM model, write scoreboard, table-driven full loads plus corner sequences.
module tb_mem_stream_loader;

  localparam int DEPTH      = 32;
  localparam int NBYTES     = DEPTH * 4;
  localparam int B2B_CYCLES = 5 * DEPTH + 2 * DEPTH + 2;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic        mem_debugaccess;
  logic        mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] checksum;

  mem_stream_loader #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .mem_address     (mem_address),
    .mem_byteenable  (mem_byteenable),
    .mem_chipselect  (mem_chipselect),
    .mem_write       (mem_write),
    .mem_debugaccess (mem_debugaccess),
    .mem_clken       (mem_clken),
    .mem_writedata   (mem_writedata),
    .mem_readdata    (mem_readdata),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .checksum        (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Single-port RAM model, one-cycle read latency, corruptible read of word 7.
  logic [31:0] ram [DEPTH];
  logic [31:0] rd_q;
  logic        corrupt7;

  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        if (mem_debugaccess) begin
          for (int l = 0; l < 4; l++)
            if (mem_byteenable[l]) ram[mem_address][8*l +: 8] <= mem_writedata[8*l +: 8];
        end
      end else begin
        rd_q <= (corrupt7 && mem_address == 5'd7) ? 32'hDEADBEEF : ram[mem_address];
      end
    end
  end
  assign mem_readdata = rd_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t  wr_q[$];
  int   wr_cnt   = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic prev_write = 1'b0;
  logic prev_done  = 1'b0;

  // Write/done monitor: pops expected writes and checks strobe widths.
  initial forever begin
    wr_t exp_w;
    @(negedge clk);
    if (reset_n && mem_write) begin
      wr_cnt++;
      check("wr_one_cycle", 32'(prev_write), 32'd0);
      check("wr_debugaccess", 32'(mem_debugaccess), 32'd1);
      check("wr_pending", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        exp_w = wr_q.pop_front();
        check("wr_addr", 32'(mem_address), 32'(exp_w.addr));
        check("wr_data", mem_writedata, exp_w.data);
      end
    end
    if (reset_n && done) begin
      done_cnt++;
      done_cyc = cyc;
      check("done_one_cycle", 32'(prev_done), 32'd0);
    end
    prev_write = mem_write;
    prev_done  = done;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time %0t exceeded the simulation limit", $time);
    $fatal(1, "watchdog expired");
  end

  logic [7:0]  data_b  [NBYTES];
  logic [31:0] exp_img [DEPTH];
  logic [31:0] exp_sum;

  task automatic make_data(input bit rnd);
    exp_sum = '0;
    for (int i = 0; i < NBYTES; i++) data_b[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(i);
    for (int w = 0; w < DEPTH; w++) begin
      exp_img[w] = {data_b[4*w+3], data_b[4*w+2], data_b[4*w+1], data_b[4*w]};
      exp_sum    = exp_sum + exp_img[w];
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall, input bit with_abort);
    int guard;
    if (stall > 0) begin
      in_valid = 1'b0;
      repeat (stall) @(posedge clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    abort    = with_abort;
    guard    = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!in_ready && guard < 1000);
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    abort    = 1'b0;
  endtask

  // Pulses start with the first byte already offered; streams nbytes; optional start pulse while busy.
  task automatic start_stream(input string name, input int stall, input int busy_start,
                              input int nbytes, input bit abort_last, output int t_start);
    in_data  = data_b[0];
    in_valid = 1'b1;
    start    = 1'b1;
    t_start  = cyc;
    @(negedge clk);
    check({name, "_idle_ready"}, 32'(in_ready), 32'd0);
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    fork
      begin
        for (int i = 0; i < nbytes; i++) begin
          if (i % 4 == 0 && !(abort_last && i + 4 >= nbytes))
            wr_q.push_back('{addr: 5'(i / 4), data: exp_img[i/4]});
          send_byte(data_b[i], (i == 0) ? 0 : stall, abort_last && (i == nbytes - 1));
        end
      end
      begin
        if (busy_start > 0) begin
          repeat (busy_start) @(posedge clk);
          #1;
          start = 1'b1;
          @(posedge clk);
          #1;
          start = 1'b0;
          @(negedge clk);
          check({name, "_busy_after_start"}, 32'(busy), 32'd1);
        end
      end
    join
  endtask

  task automatic run_load(input string name, input int stall, input int busy_start,
                          input bit exp_err, input bit chk_cycles);
    int base_done, base_wr, guard, t_start, bad;
    base_done = done_cnt;
    base_wr   = wr_cnt;
    start_stream(name, stall, busy_start, NBYTES, 1'b0, t_start);
    guard = 0;
    while (done_cnt == base_done && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    repeat (4) @(negedge clk);
    check({name, "_done_count"}, 32'(done_cnt - base_done), 32'd1);
    if (chk_cycles) check({name, "_done_latency"}, 32'(done_cyc - t_start), 32'(B2B_CYCLES));
    check({name, "_writes"}, 32'(wr_cnt - base_wr), 32'(DEPTH));
    check({name, "_queue_empty"}, 32'(wr_q.size()), 32'd0);
    check({name, "_checksum"}, checksum, exp_sum);
    check({name, "_error"}, 32'(error), 32'(exp_err));
    check({name, "_busy_idle"}, 32'(busy), 32'd0);
    bad = 0;
    for (int w = 0; w < DEPTH; w++) if (ram[w] !== exp_img[w]) bad++;
    check({name, "_ram_image"}, 32'(bad), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_in_ready"}, 32'(in_ready), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_error"}, 32'(error), 32'd0);
    check({name, "_checksum"}, checksum, 32'd0);
    check({name, "_cs"}, 32'(mem_chipselect), 32'd0);
    check({name, "_write"}, 32'(mem_write), 32'd0);
    check({name, "_dbg"}, 32'(mem_debugaccess), 32'd0);
    check({name, "_addr"}, 32'(mem_address), 32'd0);
    check({name, "_wdata"}, mem_writedata, 32'd0);
    check({name, "_clken"}, 32'(mem_clken), 32'd1);
    check({name, "_be"}, 32'(mem_byteenable), 32'hF);
  endtask

  typedef struct {
    string name;
    int    stall;
    bit    corrupt;
    bit    rnd;
    int    busy_start;
    bit    exp_err;
    bit    chk_cycles;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int t_start, base_done, base_wr, guard;

    vecs[0] = '{name: "b2b",           stall: 0,  corrupt: 0, rnd: 0, busy_start: 0,   exp_err: 0, chk_cycles: 1};
    vecs[1] = '{name: "stall10",       stall: 10, corrupt: 0, rnd: 0, busy_start: 0,   exp_err: 0, chk_cycles: 0};
    vecs[2] = '{name: "corrupt7",      stall: 0,  corrupt: 1, rnd: 0, busy_start: 0,   exp_err: 1, chk_cycles: 1};
    vecs[3] = '{name: "busy_collect",  stall: 0,  corrupt: 0, rnd: 1, busy_start: 40,  exp_err: 0, chk_cycles: 1};
    vecs[4] = '{name: "busy_readback", stall: 0,  corrupt: 0, rnd: 1, busy_start: 190, exp_err: 0, chk_cycles: 1};

    reset_n  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    corrupt7 = 1'b0;
    #1;
    check_reset_outs("por");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++) begin
      make_data(vecs[v].rnd);
      corrupt7 = vecs[v].corrupt;
      run_load(vecs[v].name, vecs[v].stall, vecs[v].busy_start, vecs[v].exp_err, vecs[v].chk_cycles);
      corrupt7 = 1'b0;
    end

    // Abort in the cycle the 4th byte of word 5 is accepted.
    make_data(1'b0);
    base_done = done_cnt;
    base_wr   = wr_cnt;
    start_stream("abort", 0, 0, 24, 1'b1, t_start);
    @(negedge clk);
    check("abort_busy_falls", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - base_done), 32'd0);
    check("abort_writes", 32'(wr_cnt - base_wr), 32'd5);
    check("abort_queue_empty", 32'(wr_q.size()), 32'd0);
    @(posedge clk);
    #1;
    run_load("restart", 0, 0, 1'b0, 1'b1);

    // Reset dropped mid-readback must clear outputs before the next clock edge.
    make_data(1'b1);
    base_wr = wr_cnt;
    start_stream("rst", 0, 0, NBYTES, 1'b0, t_start);
    guard = 0;
    while (wr_cnt - base_wr < DEPTH && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("rst_writes_done", 32'(wr_cnt - base_wr), 32'(DEPTH));
    repeat (10) @(posedge clk);
    #1;
    check("rst_in_readback", 32'(mem_chipselect), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outs("rst_async");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    wr_q.delete();
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
